bus_mux_reg: RTL and testbench
==============================

# bus_mux_reg

Parametrised, registered successor to the processor's combinational bus multiplexer. Selects one of the G register, the external DIN port, or one of NREG general registers onto the shared processor bus. Captures the result in an output register and keeps the last driven value when no source is enabled. Detects and counts bus-drive conflicts so the control FSM and the testbench can flag illegal control words.

## Interface

Parameters:
- WIDTH, 9: bus and register data width in bits.
- NREG, 8: number of general registers (R0..R(NREG-1)); legal range 1-16.
- CNT_W, 8: width of the conflict counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- g_in  in  WIDTH  G register value.
- DIN  in  WIDTH  external data input.
- r_in  in  NREG*WIDTH  register file, flattened; R[i] occupies bits [i*WIDTH +: WIDTH].
- r_out  in  NREG  one-hot register drive enables.
- g_out  in  1  drive G onto the bus.
- DIN_out  in  1  drive DIN onto the bus.
- hold  in  1  freeze the bus register and the valid flag.
- clr_err  in  1  clear the sticky conflict flag and the conflict counter.
- bus  out  WIDTH  registered bus value.
- bus_valid  out  1  high when `bus` was loaded from an enabled source in the previous cycle.
- conflict  out  1  sticky; set when more than one drive enable was high in any non-hold cycle.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

## Operation

- Drive enables are the set E = {g_out, DIN_out, r_out[0..NREG-1]}.
- Source priority:
  - g_out has the highest priority.
  - DIN_out is next.
  - After that, the lowest-indexed set bit of r_out.
  - The winner is always driven, even when a conflict exists.
- Non-hold cycle with at least one enable set: `bus` <= winner and `bus_valid` <= 1.
- Non-hold cycle with no enable set: `bus` keeps its value (bus keeper) and `bus_valid` <= 0.
- Conflict: the population count of E is at least 2 in a non-hold cycle. On such a cycle:
  - `conflict` <= 1.
  - `conflict_cnt` <= `conflict_cnt` + 1, saturating at 2^CNT_W-1.
- hold = 1:
  - `bus` and `bus_valid` are unchanged.
  - Enables are ignored, and no conflict is detected or counted.
- clr_err = 1:
  - `conflict` <= 0 and `conflict_cnt` <= 0.
  - clr_err takes priority over a conflict in the same cycle, so the conflict in that cycle is lost.
- Reset values: `bus` = 0, `bus_valid` = 0, `conflict` = 0, `conflict_cnt` = 0. Reset takes priority over hold and clr_err.
- No state machine beyond the registers above. The block is a registered datapath with a sticky status register and a saturating counter.

## Timing

- Latency is 1 cycle: enables and data sampled at edge N appear on `bus`/`bus_valid` after edge N. Data must be stable at the same edge as its enable.
- `conflict` and `conflict_cnt` update on the same edge as `bus`.
- Back-to-back selects of different sources produce a new bus value every cycle; no bubbles are required.
- Reset asserted mid-transfer: the next edge clears all outputs, and the value sampled in that cycle is discarded.
- Counter saturation: at the maximum value a further conflict leaves the counter at the maximum and `conflict` at 1.
- Combinational paths are input -> register only; no input reaches an output combinationally.

## Test plan

With WIDTH=9, NREG=8, CNT_W=8:
1. Reset, then check outputs at the first post-reset edge -> bus=0, bus_valid=0, conflict=0, conflict_cnt=0.
2. Single-source sweep:
   - Set R[i]=9'h100+i and drive r_out=1<<i for i=0..7 on consecutive cycles -> each cycle after shows bus=9'h100+i and bus_valid=1.
   - Then g_out=1 with g_in=9'h1AB -> bus=9'h1AB.
   - Then DIN_out=1 with DIN=9'h055 -> bus=9'h055.
3. Priority and conflict:
   - g_out=1, DIN_out=1, r_out=8'h05, g_in=9'h0F0 -> bus=9'h0F0, conflict=1, conflict_cnt=1.
   - Next cycle r_out=8'h0C only, R2=9'h022 -> bus=9'h022, conflict_cnt=2.
4. Keeper and hold:
   - After bus=9'h022, all enables low -> bus stays 9'h022 and bus_valid=0.
   - hold=1 with g_out=1, DIN_out=1 -> bus, bus_valid, conflict and conflict_cnt all unchanged.
5. Error clear and saturation:
   - Apply 300 consecutive conflicting cycles -> conflict_cnt=8'hFF and holds there.
   - clr_err=1 together with a conflict -> next edge conflict=0 and conflict_cnt=0.
6. Reset mid-operation: assert reset in the same cycle as r_out=8'h80, R7=9'h1FF -> bus=0, bus_valid=0, and all counters cleared.

Source files
------------

// File: rtl/bus_mux_reg.sv
// ---------------------------------------------------------------------------
// bus_mux_reg
//
// Registered processor bus multiplexer. One source is selected onto the
// shared bus each cycle: the G register, the external DIN port, or one of
// NREG general registers. The selected value is captured in an output
// register. The register keeps its last value when no source is enabled.
// Cycles where more than one source tries to drive the bus are flagged in a
// sticky status bit and counted in a saturating counter.
//
// Parameters
//   WIDTH   bus / register data width
//   NREG    number of general registers R0..R(NREG-1), 1..16
//   CNT_W   conflict counter width
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   g_in          in   G register value
//   DIN           in   external data input
//   r_in          in   flattened register file, R[i] = r_in[i*WIDTH +: WIDTH]
//   r_out         in   one-hot register drive enables
//   g_out         in   drive G onto the bus (highest priority)
//   DIN_out       in   drive DIN onto the bus (second priority)
//   hold          in   freeze bus/bus_valid, ignore enables
//   clr_err       in   clear conflict flag and counter
//   bus           out  registered bus value
//   bus_valid     out  bus was loaded from an enabled source last cycle
//   conflict      out  sticky multi-driver flag
//   conflict_cnt  out  saturating count of conflict cycles
// ---------------------------------------------------------------------------
module bus_mux_reg #(
    parameter int WIDTH = 9,
    parameter int NREG  = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      g_in,
    input  logic [WIDTH-1:0]      DIN,
    input  logic [NREG*WIDTH-1:0] r_in,
    input  logic [NREG-1:0]       r_out,
    input  logic                  g_out,
    input  logic                  DIN_out,
    input  logic                  hold,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      bus,
    output logic                  bus_valid,
    output logic                  conflict,
    output logic [CNT_W-1:0]      conflict_cnt
);

    // Enough bits to count every enable (NREG registers + G + DIN).
    localparam int POP_W = $clog2(NREG + 3);

    logic [WIDTH-1:0] r_bus;
    logic             r_bus_valid;
    logic             r_conflict;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic [WIDTH-1:0] w_reg_data;
    logic             w_reg_any;
    logic [WIDTH-1:0] w_winner;
    logic             w_any_en;
    logic [POP_W-1:0] w_pop;
    logic             w_multi;
    logic             w_cnt_max;

    // Lowest-indexed active register wins: scan from the top down so the
    // last assignment made is the lowest set bit.
    always_comb begin
        w_reg_data = '0;
        w_reg_any  = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (r_out[i]) begin
                w_reg_data = r_in[i*WIDTH +: WIDTH];
                w_reg_any  = 1'b1;
            end
        end
    end

    // Fixed priority G > DIN > registers. The winner is driven even when
    // several enables are active.
    always_comb begin
        w_winner = w_reg_data;
        if (g_out) begin
            w_winner = g_in;
        end else if (DIN_out) begin
            w_winner = DIN;
        end
    end

    assign w_any_en = g_out | DIN_out | w_reg_any;

    // Population count of all enables; two or more is a conflict.
    always_comb begin
        w_pop = POP_W'(g_out) + POP_W'(DIN_out);
        for (int i = 0; i < NREG; i++) begin
            w_pop = w_pop + POP_W'(r_out[i]);
        end
    end

    assign w_multi   = (w_pop >= POP_W'(2));
    assign w_cnt_max = &r_conflict_cnt;

    // Bus register with keeper behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bus       <= '0;
            r_bus_valid <= 1'b0;
        end else if (!hold) begin
            if (w_any_en) begin
                r_bus       <= w_winner;
                r_bus_valid <= 1'b1;
            end else begin
                r_bus_valid <= 1'b0;
            end
        end
    end

    // Conflict status. clr_err wins over a conflict in the same cycle,
    // and hold suppresses detection entirely.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (clr_err) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (!hold && w_multi) begin
            r_conflict <= 1'b1;
            if (!w_cnt_max) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign bus          = r_bus;
    assign bus_valid    = r_bus_valid;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_bus_mux_reg
//
// Directed bench for bus_mux_reg (WIDTH=9, NREG=8, CNT_W=8). Each step drives
// one cycle of inputs, computes the expected registered outputs from a
// behavioural model and queues them. After the clock edge the entry is popped
// and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_bus_mux_reg;

    localparam int WIDTH = 9;
    localparam int NREG  = 8;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [WIDTH-1:0] bus;
        logic             valid;
        logic             conflict;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic                  clock;
    logic                  reset;
    logic [WIDTH-1:0]      g_in;
    logic [WIDTH-1:0]      din;
    logic [NREG*WIDTH-1:0] r_in;
    logic [NREG-1:0]       r_out;
    logic                  g_out;
    logic                  din_out;
    logic                  hold;
    logic                  clr_err;
    logic [WIDTH-1:0]      bus;
    logic                  bus_valid;
    logic                  conflict;
    logic [CNT_W-1:0]      conflict_cnt;

    bus_mux_reg #(.WIDTH(WIDTH), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .g_in         (g_in),
        .DIN          (din),
        .r_in         (r_in),
        .r_out        (r_out),
        .g_out        (g_out),
        .DIN_out      (din_out),
        .hold         (hold),
        .clr_err      (clr_err),
        .bus          (bus),
        .bus_valid    (bus_valid),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t sb[$];
    exp_t m;          // model state
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic set_reg(input int idx, input logic [WIDTH-1:0] val);
        r_in[idx*WIDTH +: WIDTH] = val;
    endtask

    // Reference model: priority select, keeper, conflict tracking.
    task automatic model_cycle();
        int               pop;
        logic [WIDTH-1:0] win;
        logic             found;
        if (reset) begin
            m = '0;
            return;
        end
        pop = int'(g_out) + int'(din_out);
        found = 1'b0;
        win = '0;
        for (int i = 0; i < NREG; i++) begin
            if (r_out[i]) begin
                pop++;
                if (!found) begin
                    win   = r_in[i*WIDTH +: WIDTH];
                    found = 1'b1;
                end
            end
        end
        if (din_out) win = din;
        if (g_out)   win = g_in;
        if (!hold) begin
            if (pop >= 1) begin
                m.bus   = win;
                m.valid = 1'b1;
            end else begin
                m.valid = 1'b0;
            end
        end
        if (clr_err) begin
            m.conflict = 1'b0;
            m.cnt      = '0;
        end else if (!hold && pop >= 2) begin
            m.conflict = 1'b1;
            if (m.cnt != {CNT_W{1'b1}}) m.cnt = m.cnt + 1'b1;
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard empty observed=0 expected=1 entry", tag);
            return;
        end
        e = sb.pop_front();
        assert (bus === e.bus) else begin
            n_err++;
            $error("FAIL %s bus observed=%h expected=%h", tag, bus, e.bus);
        end
        n_cmp++;
        assert (bus_valid === e.valid) else begin
            n_err++;
            $error("FAIL %s bus_valid observed=%b expected=%b", tag, bus_valid, e.valid);
        end
        n_cmp++;
        assert (conflict === e.conflict) else begin
            n_err++;
            $error("FAIL %s conflict observed=%b expected=%b", tag, conflict, e.conflict);
        end
        n_cmp++;
        assert (conflict_cnt === e.cnt) else begin
            n_err++;
            $error("FAIL %s conflict_cnt observed=%h expected=%h", tag, conflict_cnt, e.cnt);
        end
    endtask

    // One cycle: drive controls, queue expectation, clock, compare.
    task automatic step(input string tag, input logic g, input logic d,
                        input logic [NREG-1:0] r, input logic h,
                        input logic c, input logic rst);
        g_out   = g;
        din_out = d;
        r_out   = r;
        hold    = h;
        clr_err = c;
        reset   = rst;
        model_cycle();
        sb.push_back(m);
        @(posedge clock);
        #1;
        check(tag);
    endtask

    // Direct comparison against literal values from the test plan.
    task automatic expect_lit(input string tag, input logic [WIDTH-1:0] b,
                              input logic v, input logic c,
                              input logic [CNT_W-1:0] n);
        n_cmp++;
        assert (bus === b && bus_valid === v && conflict === c && conflict_cnt === n) else begin
            n_err++;
            $error("FAIL %s observed=%h/%b/%b/%h expected=%h/%b/%b/%h",
                   tag, bus, bus_valid, conflict, conflict_cnt, b, v, c, n);
        end
    endtask

    initial begin
        m       = '0;
        reset   = 1'b1;
        g_in    = '0;
        din     = '0;
        r_in    = '0;
        r_out   = '0;
        g_out   = 1'b0;
        din_out = 1'b0;
        hold    = 1'b0;
        clr_err = 1'b0;
        @(posedge clock);
        #1;

        // 1. reset
        step("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_lit("reset_lit", 9'h000, 1'b0, 1'b0, 8'h00);
        step("idle_after_reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 2. single-source sweep
        for (int i = 0; i < NREG; i++) set_reg(i, 9'(9'h100 + i));
        for (int i = 0; i < NREG; i++) begin
            step($sformatf("sweep_r%0d", i), 1'b0, 1'b0, 8'(1 << i), 1'b0, 1'b0, 1'b0);
            expect_lit($sformatf("sweep_lit_r%0d", i), 9'(9'h100 + i), 1'b1, 1'b0, 8'h00);
        end
        g_in = 9'h1AB;
        step("sel_g", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_lit("sel_g_lit", 9'h1AB, 1'b1, 1'b0, 8'h00);
        din = 9'h055;
        step("sel_din", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_lit("sel_din_lit", 9'h055, 1'b1, 1'b0, 8'h00);

        // 3. priority and conflict
        g_in = 9'h0F0;
        step("prio_g", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        expect_lit("prio_g_lit", 9'h0F0, 1'b1, 1'b1, 8'h01);
        set_reg(2, 9'h022);
        step("prio_r2", 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0);
        expect_lit("prio_r2_lit", 9'h022, 1'b1, 1'b1, 8'h02);
        step("prio_din", 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        step("prio_r3", 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        set_reg(2, 9'h022);
        step("reload_r2", 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);

        // 4. keeper and hold
        step("keeper", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_lit("keeper_lit", 9'h022, 1'b0, 1'b1, 8'h03);
        step("hold", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_lit("hold_lit", 9'h022, 1'b0, 1'b1, 8'h03);
        step("after_hold_sel", 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);
        step("hold_valid", 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);

        // 5. saturation and clear
        for (int k = 0; k < 300; k++) begin
            g_in = 9'(k);
            step("sat", 1'b1, 1'b0, 8'(k | 1), 1'b0, 1'b0, 1'b0);
        end
        expect_lit("sat_lit", 9'(299), 1'b1, 1'b1, 8'hFF);
        step("sat_again", 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step("clr_with_conflict", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_lit("clr_lit", 9'(299), 1'b1, 1'b0, 8'h00);
        step("post_clr_conflict", 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        step("clr_during_hold", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // 6. reset mid-operation
        step("pre_reset_conflict", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        set_reg(7, 9'h1FF);
        step("reset_mid", 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
        expect_lit("reset_mid_lit", 9'h000, 1'b0, 1'b0, 8'h00);
        step("after_reset_r7", 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
        expect_lit("after_reset_r7_lit", 9'h1FF, 1'b1, 1'b0, 8'h00);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
